// File: rtl/spi_flash_cmd.sv
// Command sequencer feeding a byte-wide SPI master: opcode, optional 24-bit address, payload, then a CS-release gap.
// Optional write-enable preamble (0x06 sent as its own transaction) is built only when SPI_FLASH_WREN_EN is defined.
module spi_flash_cmd #(
    parameter int GAP_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_opcode,
    input  logic [23:0] cmd_addr,
    input  logic        cmd_addr_en,
    input  logic [8:0]  cmd_len,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  data,
    output logic        valid,
    input  logic        ready,
    output logic        busy,
    output logic        done,
    output logic        underrun
);

    localparam logic [2:0] IDLE  = 3'd0;
`ifdef SPI_FLASH_WREN_EN
    localparam logic [2:0] WREN  = 3'd1;
    localparam logic [2:0] WGAP  = 3'd2;
`endif
    localparam logic [2:0] OPC   = 3'd3;
    localparam logic [2:0] ADDR  = 3'd4;
    localparam logic [2:0] PAY   = 3'd5;
    localparam logic [2:0] DRAIN = 3'd6;
    localparam logic [2:0] GAP   = 3'd7;

    localparam int TW = $clog2(GAP_CYCLES + 3);
    localparam logic [TW-1:0] DRAIN_LAST = TW'(2);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);

    logic [2:0]    state;
    logic          armed;
    logic [7:0]    opc_q;
    logic [23:0]   addr_q;
    logic          addr_en_q;
    logic [8:0]    pay_cnt;
    logic [1:0]    byte_cnt;
    logic [TW-1:0] tmr;
    logic          done_q;
    logic          under_q;
    logic          accept;
`ifdef SPI_FLASH_WREN_EN
    logic          gap_ph;

    function automatic logic needs_wren(input logic [7:0] op);
        return (op == 8'h02) || (op == 8'h20) || (op == 8'hD8) || (op == 8'hC7);
    endfunction
`endif

    // armed keeps cmd_ready low until the first clock after reset release
    assign cmd_ready = (state == IDLE) && armed;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign underrun  = under_q;
    assign wr_ready  = (state == PAY) && ready;

    always_comb begin
        data  = 8'h00;
        valid = 1'b0;
        case (state)
`ifdef SPI_FLASH_WREN_EN
            WREN: begin
                data  = 8'h06;
                valid = 1'b1;
            end
`endif
            OPC: begin
                data  = opc_q;
                valid = 1'b1;
            end
            ADDR: begin
                valid = 1'b1;
                case (byte_cnt)
                    2'd0:    data = addr_q[23:16];
                    2'd1:    data = addr_q[15:8];
                    default: data = addr_q[7:0];
                endcase
            end
            PAY: begin
                data  = wr_data;
                valid = wr_valid;
            end
            default: begin
                data  = 8'h00;
                valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            armed     <= 1'b0;
            opc_q     <= 8'h00;
            addr_q    <= 24'h0;
            addr_en_q <= 1'b0;
            pay_cnt   <= 9'd0;
            byte_cnt  <= 2'd0;
            tmr       <= '0;
            done_q    <= 1'b0;
            under_q   <= 1'b0;
`ifdef SPI_FLASH_WREN_EN
            gap_ph    <= 1'b0;
`endif
        end else begin
            armed  <= 1'b1;
            done_q <= 1'b0;
            if (state == PAY && ready && !wr_valid)
                under_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        opc_q     <= cmd_opcode;
                        addr_q    <= cmd_addr;
                        addr_en_q <= cmd_addr_en;
                        pay_cnt   <= cmd_len;
                        byte_cnt  <= 2'd0;
                        tmr       <= '0;
                        under_q   <= 1'b0;
`ifdef SPI_FLASH_WREN_EN
                        state     <= needs_wren(cmd_opcode) ? WREN : OPC;
`else
                        state     <= OPC;
`endif
                    end
                end
`ifdef SPI_FLASH_WREN_EN
                WREN: begin
                    if (ready) begin
                        state  <= WGAP;
                        tmr    <= '0;
                        gap_ph <= 1'b0;
                    end
                end
                // Same drain-then-gap sequence as DRAIN/GAP, tracked by gap_ph
                WGAP: begin
                    if (!gap_ph) begin
                        if (tmr == DRAIN_LAST) begin
                            if (ready) begin
                                gap_ph <= 1'b1;
                                tmr    <= '0;
                            end
                        end else begin
                            tmr <= tmr + TW'(1);
                        end
                    end else if (tmr == GAP_LAST) begin
                        state  <= OPC;
                        gap_ph <= 1'b0;
                        tmr    <= '0;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
`endif
                OPC: begin
                    if (ready) begin
                        tmr      <= '0;
                        byte_cnt <= 2'd0;
                        if (addr_en_q)
                            state <= ADDR;
                        else
                            state <= (pay_cnt != 9'd0) ? PAY : DRAIN;
                    end
                end
                ADDR: begin
                    if (ready) begin
                        if (byte_cnt == 2'd2) begin
                            state <= (pay_cnt != 9'd0) ? PAY : DRAIN;
                            tmr   <= '0;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                // pay_cnt holds 1..256 here, so the last transfer lands on 0 without wrapping
                PAY: begin
                    if (wr_valid && ready) begin
                        pay_cnt <= pay_cnt - 9'd1;
                        if (pay_cnt == 9'd1) begin
                            state <= DRAIN;
                            tmr   <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (tmr == DRAIN_LAST) begin
                        if (ready) begin
                            state <= GAP;
                            tmr   <= '0;
                        end
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
                GAP: begin
                    if (tmr == GAP_LAST) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                        tmr    <= '0;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_cmd.sv
// Directed bench for spi_flash_cmd: expected SPI bytes are queued when a command is issued and popped on each transfer.
// Follows SPI_FLASH_WREN_EN so the same bench covers both builds.
module tb_spi_flash_cmd;

    localparam int GAP = 8;
`ifdef SPI_FLASH_WREN_EN
    localparam int WREN_X = 1;
`else
    localparam int WREN_X = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode;
    logic [23:0] cmd_addr;
    logic        cmd_addr_en;
    logic [8:0]  cmd_len;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  data;
    logic        valid;
    logic        ready;
    logic        busy;
    logic        done;
    logic        underrun;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
    logic [7:0] pay_q[$];
    int         gaps_q[$];
    int         xfer_cnt = 0;
    int         wr_cnt   = 0;
    int         done_cnt = 0;
    int         low_run  = 0;
    int         last_low = 0;
    logic       mon_xfer = 1'b0;
    logic       mon_wr   = 1'b0;
    logic       hold_v   = 1'b0;
    logic [7:0] hold_d   = 8'h00;
    logic       bp_mode  = 1'b0;
    int         stall_req = 0;

    spi_flash_cmd #(.GAP_CYCLES(GAP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_addr   (cmd_addr),
        .cmd_addr_en(cmd_addr_en),
        .cmd_len    (cmd_len),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Monitor: scoreboard pop on every transfer, hold-stability under backpressure, done/gap bookkeeping
    always @(negedge clk) begin
        mon_xfer = valid && ready;
        mon_wr   = wr_valid && wr_ready;
        if (rst_n) begin
            if (hold_v)
                chk("hold_stable", 32'({valid, data}), 32'({1'b1, hold_d}));
            if (valid && ready) begin
                if (exp_q.size() == 0)
                    chk("extra_byte", 32'(data), 32'hFFFF_FFFF);
                else
                    chk("byte", 32'(data), 32'(exp_q.pop_front()));
                xfer_cnt++;
                gaps_q.push_back(low_run);
                low_run = 0;
            end else if (!valid) begin
                low_run++;
            end
            if (mon_wr) wr_cnt++;
            if (done) begin
                done_cnt++;
                last_low = low_run;
            end
            hold_v = valid && !ready;
            hold_d = data;
        end else begin
            hold_v = 1'b0;
        end
    end

    // Master ready: always high, or low for 20 cycles after each transfer in backpressure mode
    initial begin
        ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode && mon_xfer) begin
                ready = 1'b0;
                repeat (20) @(posedge clk);
                #1;
                ready = 1'b1;
            end
        end
    end

    // Payload source: presents head of pay_q, pops on handshake, optional stall window
    initial begin
        logic [7:0] tmp;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (mon_wr && pay_q.size() > 0) tmp = pay_q.pop_front();
            if (stall_req > 0) begin
                wr_valid = 1'b0;
                stall_req--;
            end else if (pay_q.size() > 0) begin
                wr_valid = 1'b1;
                wr_data  = pay_q[0];
            end else begin
                wr_valid = 1'b0;
                wr_data  = 8'h00;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [23:0] addr, input logic aen,
                            input logic [8:0] len, input logic hold);
        for (int i = 0; i < 300 && !cmd_ready; i++) step();
        chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
`ifdef SPI_FLASH_WREN_EN
        if (op == 8'h02 || op == 8'h20 || op == 8'hD8 || op == 8'hC7) exp_q.push_back(8'h06);
`endif
        exp_q.push_back(op);
        if (aen) begin
            exp_q.push_back(addr[23:16]);
            exp_q.push_back(addr[15:8]);
            exp_q.push_back(addr[7:0]);
        end
        foreach (pay_q[k]) exp_q.push_back(pay_q[k]);
        cmd_valid   = 1'b1;
        cmd_opcode  = op;
        cmd_addr    = addr;
        cmd_addr_en = aen;
        cmd_len     = len;
        @(posedge clk);
        #1;
        cmd_opcode  = ~op;
        cmd_addr    = ~addr;
        cmd_addr_en = ~aen;
        cmd_len     = 9'h155;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int start;
        start = done_cnt;
        for (int i = 0; i < budget && done_cnt == start; i++) step();
        chk({tag, "_done"}, 32'(done_cnt), 32'(start + 1));
        chk({tag, "_exp_empty"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        step();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int sx, sw, sd;
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_opcode  = 8'h00;
        cmd_addr    = 24'h0;
        cmd_addr_en = 1'b0;
        cmd_len     = 9'd0;
        repeat (3) step();

        // Reset values
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("cmd_ready_before_clk", 32'(cmd_ready), 32'd0);
        step();
        chk("cmd_ready_after_clk", 32'(cmd_ready), 32'd1);

        // Read-ID
        sx = xfer_cnt;
        send_cmd(8'h9F, 24'h0, 1'b0, 9'd0, 1'b0);
        wait_done("rdid", 200);
        chk("rdid_bytes", 32'(xfer_cnt - sx), 32'd1);
        chk("rdid_gap_min", 32'(last_low >= GAP), 32'd1);
        chk("rdid_gap_max", 32'(last_low <= GAP + 6), 32'd1);

        // Page program
        sx = xfer_cnt;
        sw = wr_cnt;
        gaps_q.delete();
        pay_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        send_cmd(8'h02, 24'h123456, 1'b1, 9'd4, 1'b0);
        wait_done("pp", 400);
        chk("pp_bytes", 32'(xfer_cnt - sx), 32'(8 + WREN_X));
        chk("pp_payload", 32'(wr_cnt - sw), 32'd4);
`ifdef SPI_FLASH_WREN_EN
        chk("pp_wren_gap", 32'(gaps_q[1] >= GAP), 32'd1);
`endif

        // Backpressure
        sx = xfer_cnt;
        bp_mode = 1'b1;
        pay_q = '{8'h11, 8'h22};
        send_cmd(8'h03, 24'h00ABCD, 1'b1, 9'd2, 1'b0);
        wait_done("bp", 1500);
        bp_mode = 1'b0;
        chk("bp_bytes", 32'(xfer_cnt - sx), 32'd6);

        // Underrun: stall the payload source mid-stream
        pay_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
        send_cmd(8'h02, 24'h000100, 1'b1, 9'd4, 1'b0);
        for (int i = 0; i < 400 && pay_q.size() > 2; i++) step();
        stall_req = 5;
        wait_done("ur", 400);
        chk("ur_set_at_done", 32'(underrun), 32'd1);
        step();
        chk("ur_sticky", 32'(underrun), 32'd1);
        send_cmd(8'h9F, 24'h0, 1'b0, 9'd0, 1'b0);
        chk("ur_cleared", 32'(underrun), 32'd0);
        wait_done("ur_next", 200);

        // Reset mid-ADDR
        sx = xfer_cnt;
        sd = done_cnt;
        send_cmd(8'h0B, 24'h654321, 1'b1, 9'd0, 1'b0);
        for (int i = 0; i < 50 && xfer_cnt < sx + 2; i++) step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        chk("mid_rst_ready_next", 32'(cmd_ready), 32'd1);
        repeat (20) step();
        chk("mid_rst_no_done", 32'(done_cnt), 32'(sd));

        // len = 256 with cmd_valid held high while busy
        sx = xfer_cnt;
        sw = wr_cnt;
        for (int i = 0; i < 256; i++) pay_q.push_back(8'(i) ^ 8'h5A);
        send_cmd(8'h02, 24'h00FF00, 1'b1, 9'd256, 1'b1);
        for (int i = 0; i < 3000 && exp_q.size() > 0; i++) begin
            step();
            if (i == 100) begin
                chk("l256_no_accept", 32'(cmd_ready), 32'd0);
                chk("l256_busy", 32'(busy), 32'd1);
            end
        end
        step();
        chk("l256_drain_valid", 32'(valid), 32'd0);
        chk("l256_drain_wr_ready", 32'(wr_ready), 32'd0);
        chk("l256_drain_busy", 32'(busy), 32'd1);
        chk("l256_payload", 32'(wr_cnt - sw), 32'd256);
        cmd_valid = 1'b0;
        wait_done("l256", 400);
        chk("l256_bytes", 32'(xfer_cnt - sx), 32'(260 + WREN_X));
        step();
        chk("l256_idle_after", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
